// File: rtl/ahb_lite_wait_ram.sv
// AHB-Lite single-slave RAM responder with WAIT_STATES HREADY-low cycles per data phase.
// Define AHB_LITE_WAIT_RAM_ERROR_EN to answer unaligned accesses with a two-cycle ERROR.
module ahb_lite_wait_ram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

`ifdef AHB_LITE_WAIT_RAM_ERROR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_e;
`endif

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              lo_q;
  logic [1:0]              size_q;
  logic                    write_q;
  logic                    hready_q, hready_d;
  logic [31:0]             hrdata_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    accept_c;
  logic [1:0]              size_c;
  logic [1:0]              lo_c;
  logic                    from_wait_c;
  logic [ADDR_WIDTH-1:0]   rd_idx_c;
  logic                    rd_load_c;
  logic                    wr_en_c;
  logic [31:0]             wr_word_c;
  logic [31:0]             rd_word_c;
  state_e                  launch_state_c;
  logic [CNT_W-1:0]        launch_cnt_c;
  logic                    unused_c;

  function automatic logic [3:0] lanes(input logic [1:0] lo, input logic [1:0] sz);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    end
    return w;
  endfunction

  assign accept_c = HSEL & hready_q & HTRANS[1];
  assign unused_c = ^{HBURST, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // Sizes above x32 behave as x32; low address bits are forced to natural alignment.
  always_comb begin
    size_c = (HSIZE > 3'd2) ? 2'd2 : HSIZE[1:0];
    case (size_c)
      2'd0:    lo_c = HADDR[1:0];
      2'd1:    lo_c = {HADDR[1], 1'b0};
      default: lo_c = 2'b00;
    endcase
  end

  // Next-state: where an accepted beat starts, then the per-state transitions.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    launch_state_c = S_DATA;
    launch_cnt_c   = '0;
    if (WAIT_STATES != 0) begin
      launch_state_c = S_WAIT;
      launch_cnt_c   = WAIT_LOAD;
    end
`ifdef AHB_LITE_WAIT_RAM_ERROR_EN
    if ((HSIZE > 3'd2) || ((HSIZE == 3'd1) && HADDR[0]) ||
        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))) begin
      launch_state_c = S_ERR1;
      launch_cnt_c   = '0;
    end
`endif
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DATA;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`ifdef AHB_LITE_WAIT_RAM_ERROR_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: begin
        if (accept_c) begin
          state_d = launch_state_c;
          cnt_d   = launch_cnt_c;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    hready_d = (state_d != S_WAIT);
`ifdef AHB_LITE_WAIT_RAM_ERROR_EN
    hready_d = hready_d && (state_d != S_ERR1);
`endif
  end

  // Read word for the DATA cycle about to start; a write finishing now is forwarded.
  always_comb begin
    from_wait_c = (state_q == S_WAIT);
    rd_idx_c    = from_wait_c ? idx_q : HADDR[ADDR_WIDTH+1:2];
    rd_load_c   = (state_d == S_DATA) && (from_wait_c ? !write_q : !HWRITE);
    wr_en_c     = (state_q == S_DATA) && write_q;
    wr_word_c   = merge_lanes(mem_q[idx_q], HWDATA, lanes(lo_q, size_q));
    rd_word_c   = (wr_en_c && (rd_idx_c == idx_q)) ? wr_word_c : mem_q[rd_idx_c];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hready_q <= 1'b1;
      hrdata_q <= '0;
      idx_q    <= '0;
      lo_q     <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      if (rd_load_c) hrdata_q <= rd_word_c;
      if (accept_c) begin
        idx_q   <= HADDR[ADDR_WIDTH+1:2];
        lo_q    <= lo_c;
        size_q  <= size_c;
        write_q <= HWRITE;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_en_c) mem_q[idx_q] <= wr_word_c;
  end

`ifdef AHB_LITE_WAIT_RAM_ERROR_EN
  logic hresp_q;
  always_ff @(posedge HCLK) begin
    if (HRESET) hresp_q <= 1'b0;
    else        hresp_q <= (state_d == S_ERR1) || (state_d == S_ERR2);
  end
  assign HRESP = hresp_q;
`else
  assign HRESP = 1'b0;
`endif

  assign HREADY = hready_q;
  assign HRDATA = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_wait_ram.sv
// Randomised bench for ahb_lite_wait_ram: two instances (2 and 0 wait states) checked each
// cycle against a transaction-level model, plus literal expectations from known sequences.
module tb_ahb_lite_wait_ram;

  localparam int unsigned AW = 10;
`ifdef AHB_LITE_WAIT_RAM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
  } beat_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        hsel_w2, hsel_w0;
  logic [31:0] hrdata_w2, hrdata_w0;
  logic        hready_w2, hready_w0;
  logic        hresp_w2, hresp_w0;

  always #5 HCLK = ~HCLK;

  ahb_lite_wait_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_w2 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST), .HSEL(hsel_w2),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(hrdata_w2), .HREADY(hready_w2), .HRESP(hresp_w2)
  );

  ahb_lite_wait_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_w0 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST), .HSEL(hsel_w0),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(hrdata_w0), .HREADY(hready_w0), .HRESP(hresp_w0)
  );

  int checks = 0;
  int fails  = 0;
  int lowcnt = 0;
  int respcnt = 0;
  int cur = 0;

  logic [31:0] mem_m [2][1024];
  bit          vld_m [2][1024];
  beat_t       q[$];
  beat_t       pend;
  int          ph_left;
  bit          ph_write, ph_err;
  int          ph_idx;
  logic [3:0]  ph_be;
  logic [31:0] ph_wdata;
  bit          exp_ready, exp_resp, rdata_known;
  logic [31:0] exp_rdata;
  int          pool [7] = '{0, 1, 4, 8, 16, 17, 1023};

  function automatic int eff_size(input logic [2:0] sz);
    return (sz > 3'd2) ? 2 : int'(sz);
  endfunction

  function automatic bit is_unaligned(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b1;
    return (int'(a[1:0]) % (1 << int'(sz))) != 0;
  endfunction

  // Bytes covered by the access after rounding the offset down to its natural boundary.
  function automatic logic [3:0] lanes_of(input logic [31:0] a, input logic [2:0] sz);
    int n  = 1 << eff_size(sz);
    int lo = (int'(a[1:0]) / n) * n;
    logic [3:0] be = '0;
    for (int b = 0; b < 4; b++) if (b >= lo && b < lo + n) be[b] = 1'b1;
    return be;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph_left = 0; exp_ready = 1'b1; exp_resp = 1'b0;
    exp_rdata = '0; rdata_known = 1'b1; pend = '0;
    q.delete();
  endtask

  task automatic model_edge();
    int ws = (cur == 0) ? 2 : 0;
    if (ph_left > 0) begin
      ph_left--;
      if (ph_left == 0 && ph_write && !ph_err) begin
        for (int b = 0; b < 4; b++)
          if (ph_be[b]) mem_m[cur][ph_idx][8*b +: 8] = ph_wdata[8*b +: 8];
        if (ph_be == 4'hF) vld_m[cur][ph_idx] = 1'b1;
      end
    end
    if (exp_ready) begin
      if (pend.sel && pend.trans[1]) begin
        ph_err   = ERR_EN && is_unaligned(pend.addr, pend.size);
        ph_left  = ph_err ? 2 : ws + 1;
        ph_write = pend.write;
        ph_idx   = int'(pend.addr[AW+1:2]);
        ph_be    = lanes_of(pend.addr, pend.size);
        ph_wdata = pend.wdata;
      end
      if (q.size() > 0) pend = q.pop_front();
      else              pend = '0;
    end
    if (ph_left > 0) begin
      exp_ready = (ph_left == 1);
      exp_resp  = ph_err;
      if (ph_left == 1 && !ph_write && !ph_err) begin
        exp_rdata   = mem_m[cur][ph_idx];
        rdata_known = vld_m[cur][ph_idx];
      end
    end else begin
      exp_ready = 1'b1;
      exp_resp  = 1'b0;
    end
  endtask

  task automatic drive();
    hsel_w2 = pend.sel && (cur == 0);
    hsel_w0 = pend.sel && (cur == 1);
    HADDR   = pend.addr;
    HTRANS  = pend.trans;
    HBURST  = pend.burst;
    HSIZE   = pend.size;
    HWRITE  = pend.write;
    HWDATA  = (ph_left > 0 && ph_write) ? ph_wdata : $urandom;
  endtask

  // One bus cycle: advance the model past the edge, drive, then compare mid-cycle.
  task automatic step();
    logic        ra, rs;
    logic [31:0] rd;
    @(posedge HCLK);
    #1;
    if (HRESET) model_reset();
    else        model_edge();
    drive();
    @(negedge HCLK);
    ra = (cur == 0) ? hready_w2 : hready_w0;
    rs = (cur == 0) ? hresp_w2  : hresp_w0;
    rd = (cur == 0) ? hrdata_w2 : hrdata_w0;
    chk("hready", 32'(ra), 32'(exp_ready));
    chk("hresp", 32'(rs), 32'(exp_resp));
    if (rdata_known) chk("hrdata", rd, exp_rdata);
    if (!ra) lowcnt++;
    if (rs)  respcnt++;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    repeat (2) step();
    HRESET = 1'b0;
  endtask

  task automatic push(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    beat_t b;
    b = '0;
    b.sel = 1'b1; b.trans = 2'b10; b.addr = a; b.size = sz; b.write = wr; b.wdata = wd;
    q.push_back(b);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() > 0 || ph_left > 0 || (pend.sel && pend.trans[1])) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      fails++;
      $display("FAIL drain: budget of %0d cycles exhausted", budget);
    end
  endtask

  task automatic pool_init();
    for (int i = 0; i < 7; i++) push(1'b1, 32'(pool[i] * 4), 3'd2, $urandom);
    drain(100);
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      int    r;
      logic [9:0] idx;
      b.sel   = ($urandom_range(0, 9) != 0);
      r       = int'($urandom_range(0, 9));
      b.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'($urandom_range(2, 3));
      b.burst = 3'($urandom_range(0, 7));
      b.addr  = $urandom;
      idx     = 10'(pool[$urandom_range(0, 6)]);
      b.addr[AW+1:2] = idx;
      b.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      b.write = 1'($urandom_range(0, 1));
      b.wdata = $urandom;
      q.push_back(b);
    end
    drain(20 * n + 50);
  endtask

  initial begin
    HRESET = 1'b1;
    model_reset();
    drive();
    do_reset();
    chk("rst_hready", 32'(hready_w2), 32'd1);
    chk("rst_hresp", 32'(hresp_w2), 32'd0);
    chk("rst_hrdata", hrdata_w2, 32'h0);
    chk("rst_hrdata_w0", hrdata_w0, 32'h0);

    // Single x32 write then read, two wait states each.
    lowcnt = 0;
    push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    push(1'b0, 32'h10, 3'd2, 32'h0);
    drain(100);
    chk("t2_rdata", hrdata_w2, 32'hDEADBEEF);
    chk("t2_lowcnt", 32'(lowcnt), 32'd4);

    // Byte lanes.
    push(1'b1, 32'h20, 3'd2, 32'h11223344);
    push(1'b1, 32'h21, 3'd0, 32'h0000AA00);
    push(1'b0, 32'h20, 3'd2, 32'h0);
    drain(100);
    chk("t3_byte", hrdata_w2, 32'h1122AA44);
    push(1'b1, 32'h22, 3'd1, 32'hBEEF0000);
    push(1'b0, 32'h20, 3'd2, 32'h0);
    drain(100);
    chk("t3_half", hrdata_w2, 32'hBEEFAA44);

    // Unaligned x32 accesses.
    respcnt = 0;
    push(1'b1, 32'h00, 3'd2, 32'hCAFEF00D);
    push(1'b0, 32'h02, 3'd2, 32'h0);
    drain(100);
    chk("t6_rdata", hrdata_w2, ERR_EN ? 32'hBEEFAA44 : 32'hCAFEF00D);
    chk("t6_resp", 32'(respcnt), ERR_EN ? 32'd2 : 32'd0);
    push(1'b1, 32'h01, 3'd2, 32'h12345678);
    push(1'b0, 32'h00, 3'd2, 32'h0);
    drain(100);
    chk("t6_array", hrdata_w2, ERR_EN ? 32'hCAFEF00D : 32'h12345678);

    // Upper address bits alias onto the same word.
    push(1'b1, 32'h1010, 3'd2, 32'h0F1E2D3C);
    push(1'b0, 32'h10, 3'd2, 32'h0);
    drain(100);
    chk("alias", hrdata_w2, 32'h0F1E2D3C);

    // Reset while a write is still waiting: it must not land.
    begin
      int n = 0;
      push(1'b1, 32'h10, 3'd2, 32'h0BADF00D);
      while (ph_left != 2 && n < 20) begin
        step();
        n++;
      end
      chk("midrst_reach", 32'(ph_left), 32'd2);
    end
    do_reset();
    chk("midrst_hrdata", hrdata_w2, 32'h0);
    push(1'b0, 32'h10, 3'd2, 32'h0);
    drain(100);
    chk("midrst_keep", hrdata_w2, 32'h0F1E2D3C);

    pool_init();
    rand_run(300);

    // Zero-wait instance: back-to-back write then read needs the bypass.
    cur = 1;
    do_reset();
    lowcnt = 0;
    push(1'b1, 32'h40, 3'd2, 32'h5A5A5A5A);
    push(1'b0, 32'h40, 3'd2, 32'h0);
    drain(100);
    chk("t4_bypass", hrdata_w0, 32'h5A5A5A5A);
    chk("t4_lowcnt", 32'(lowcnt), 32'd0);
    push(1'b1, 32'h41, 3'd0, 32'h0000C300);
    push(1'b0, 32'h40, 3'd2, 32'h0);
    drain(100);
    chk("t4_byte_bypass", hrdata_w0, 32'h5A5AC35A);

    pool_init();
    rand_run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
